// File: rtl/boss_pkg.sv
// ============================================================================
//  Module : boss_pkg
//  Brief  : Shared game-state codes, boss direction/pose encodings and helpers.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package boss_pkg;

    typedef enum logic [3:0] {
        GS_TITLE  = 4'd0,
        GS_INTRO  = 4'd1,
        GS_STAGE1 = 4'd2,
        GS_CLEAR1 = 4'd3,
        GS_STAGE2 = 4'd4,
        GS_CLEAR2 = 4'd5,
        GS_STAGE3 = 4'd6,
        GS_WIN    = 4'd7,
        GS_FAIL   = 4'd8
    } game_state_e;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        FSM_IDLE = 2'd0,
        FSM_WALK = 2'd1,
        FSM_TURN = 2'd2
    } boss_fsm_e;

    localparam logic [3:0] POSE_UP1    = 4'd0;
    localparam logic [3:0] POSE_UP2    = 4'd1;
    localparam logic [3:0] POSE_UP3    = 4'd2;
    localparam logic [3:0] POSE_RIGHT1 = 4'd3;
    localparam logic [3:0] POSE_RIGHT2 = 4'd4;
    localparam logic [3:0] POSE_RIGHT3 = 4'd5;
    localparam logic [3:0] POSE_LEFT1  = 4'd6;
    localparam logic [3:0] POSE_LEFT2  = 4'd7;
    localparam logic [3:0] POSE_LEFT3  = 4'd8;
    localparam logic [3:0] POSE_DOWN1  = 4'd9;
    localparam logic [3:0] POSE_DOWN2  = 4'd10;
    localparam logic [3:0] POSE_DOWN3  = 4'd11;

    localparam int unsigned SPRITE_W = 20;
    localparam int unsigned SPRITE_H = 20;
    localparam int unsigned SCREEN_W = 320;
    localparam int unsigned SCREEN_H = 240;

    function automatic logic [3:0] pose_code(input dir_e d, input logic [1:0] f);
        return ({2'b00, d} * 4'd3) + {2'b00, f};
    endfunction

    function automatic dir_e next_patrol_dir(input dir_e d);
        case (d)
            DIR_RIGHT: return DIR_DOWN;
            DIR_DOWN:  return DIR_LEFT;
            DIR_LEFT:  return DIR_UP;
            default:   return DIR_RIGHT;
        endcase
    endfunction

    // True when one more pixel in direction d would leave the inclusive box.
    function automatic logic move_blocked(input dir_e d,
                                          input logic [8:0] x, input logic [8:0] y,
                                          input logic [8:0] x_min, input logic [8:0] x_max,
                                          input logic [8:0] y_min, input logic [8:0] y_max);
        case (d)
            DIR_UP:    return (y <= y_min);
            DIR_DOWN:  return (y >= y_max);
            DIR_LEFT:  return (x <= x_min);
            default:   return (x >= x_max);
        endcase
    endfunction

    function automatic logic axis_aligned(input dir_e d,
                                          input logic [8:0] bx, input logic [8:0] by,
                                          input logic [8:0] px, input logic [8:0] py);
        if (d == DIR_LEFT || d == DIR_RIGHT) begin
            return (bx == px);
        end
        return (by == py);
    endfunction

    // Larger distance axis wins, ties go to x.
    function automatic dir_e chase_dir(input logic [8:0] bx, input logic [8:0] by,
                                       input logic [8:0] px, input logic [8:0] py);
        logic [8:0] dx;
        logic [8:0] dy;
        dx = (px >= bx) ? (px - bx) : (bx - px);
        dy = (py >= by) ? (py - by) : (by - py);
        if (dx >= dy) begin
            return (px > bx) ? DIR_RIGHT : DIR_LEFT;
        end
        return (py > by) ? DIR_DOWN : DIR_UP;
    endfunction

endpackage

`default_nettype wire

// File: rtl/boss_tick_gen.sv
// ============================================================================
//  Module : boss_tick_gen
//  Brief  : MOVE_DIV clock divider with enable/clear, emits a 1-cycle tick.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module boss_tick_gen #(
    parameter int unsigned MOVE_DIV = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int c_CW = $clog2(MOVE_DIV);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(MOVE_DIV - 1);

    logic [c_CW-1:0] cnt_q;
    logic            w_wrap;

    assign w_wrap = (cnt_q == c_LAST);
    assign tick   = en && w_wrap;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= w_wrap ? '0 : cnt_q + c_CW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/boss_motion_ctrl.sv
// ============================================================================
//  Module : boss_motion_ctrl
//  Brief  : STAGE3 boss position/animation sequencer (patrol walk, timed turns).
//           Define BOSS_CHASE_EN to steer toward the player instead of patrolling.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module boss_motion_ctrl
    import boss_pkg::*;
#(
    parameter int unsigned MOVE_DIV   = 500000,
    parameter int unsigned ANIM_STEPS = 4,
    parameter int unsigned TURN_CYC   = 2,
    parameter int unsigned X_MIN      = 20,
    parameter int unsigned X_MAX      = 280,
    parameter int unsigned Y_MIN      = 20,
    parameter int unsigned Y_MAX      = 200,
    parameter int unsigned SEG_LEN    = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] state,
    input  logic       freeze,
    input  logic [8:0] player_x,
    input  logic [8:0] player_y,
    output logic [8:0] boss_x,
    output logic [8:0] boss_y,
    output logic [3:0] boss_state,
    output logic       step_pulse
);

    localparam logic [8:0] c_X_MIN = 9'(X_MIN);
    localparam logic [8:0] c_X_MAX = 9'(X_MAX);
    localparam logic [8:0] c_Y_MIN = 9'(Y_MIN);
    localparam logic [8:0] c_Y_MAX = 9'(Y_MAX);

    localparam int c_AW = (ANIM_STEPS > 1) ? $clog2(ANIM_STEPS) : 1;
    localparam int c_TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
    localparam logic [c_AW-1:0] c_ANIM_LAST = c_AW'(ANIM_STEPS - 1);
    localparam logic [c_TW-1:0] c_TURN_LAST = c_TW'(TURN_CYC - 1);

    boss_fsm_e       fsm_q,   fsm_d;
    logic [8:0]      x_q,     x_d;
    logic [8:0]      y_q,     y_d;
    dir_e            dir_q,   dir_d;
    logic [1:0]      frame_q, frame_d;
    logic [c_AW-1:0] step_q,  step_d;
    logic [c_TW-1:0] turn_q,  turn_d;
    logic            pulse_q, pulse_d;

    logic       w_active;
    logic       w_run;
    logic       w_tick;
    logic       w_blocked_now;
    logic       w_blocked_next;
    logic [8:0] w_nx;
    logic [8:0] w_ny;
    dir_e       w_turn_dir;

    assign w_active = (state == GS_STAGE3);
    assign w_run    = w_active && !freeze;

    boss_tick_gen #(
        .MOVE_DIV (MOVE_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (!w_active),
        .en   (w_run),
        .tick (w_tick)
    );

`ifdef BOSS_CHASE_EN
    localparam int c_SW = $clog2(SEG_LEN + 1);
    localparam logic [c_SW-1:0] c_SEG_LEN = c_SW'(SEG_LEN);

    logic [c_SW-1:0] seg_q, seg_d;
    logic            w_both_aligned;

    assign w_both_aligned = (x_q == player_x) && (y_q == player_y);
    assign w_blocked_now  = move_blocked(dir_q, x_q, y_q, c_X_MIN, c_X_MAX, c_Y_MIN, c_Y_MAX)
                          | axis_aligned(dir_q, x_q, y_q, player_x, player_y);
    assign w_blocked_next = move_blocked(dir_q, w_nx, w_ny, c_X_MIN, c_X_MAX, c_Y_MIN, c_Y_MAX)
                          | axis_aligned(dir_q, w_nx, w_ny, player_x, player_y)
                          | ((seg_q + c_SW'(1)) == c_SEG_LEN);
    assign w_turn_dir     = chase_dir(w_nx, w_ny, player_x, player_y);
`else
    logic w_unused_player;

    assign w_unused_player = ^{player_x, player_y};
    assign w_blocked_now   = move_blocked(dir_q, x_q, y_q, c_X_MIN, c_X_MAX, c_Y_MIN, c_Y_MAX);
    assign w_blocked_next  = move_blocked(dir_q, w_nx, w_ny, c_X_MIN, c_X_MAX, c_Y_MIN, c_Y_MAX);
    assign w_turn_dir      = next_patrol_dir(dir_q);
`endif

    // Candidate position; bounds are checked first so the 9-bit math never wraps.
    always_comb begin
        w_nx = x_q;
        w_ny = y_q;
        if (!w_blocked_now) begin
            case (dir_q)
                DIR_UP:    w_ny = y_q - 9'd1;
                DIR_DOWN:  w_ny = y_q + 9'd1;
                DIR_LEFT:  w_nx = x_q - 9'd1;
                default:   w_nx = x_q + 9'd1;
            endcase
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_d   = dir_q;
        frame_d = frame_q;
        step_d  = step_q;
        turn_d  = turn_q;
        pulse_d = 1'b0;
`ifdef BOSS_CHASE_EN
        seg_d   = seg_q;
`endif
        case (fsm_q)
            FSM_IDLE: begin
                fsm_d = FSM_WALK;
            end
            FSM_WALK: begin
                if (w_tick) begin
                    if (!w_blocked_now) begin
                        x_d     = w_nx;
                        y_d     = w_ny;
                        pulse_d = 1'b1;
                        if (step_q == c_ANIM_LAST) begin
                            step_d  = '0;
                            frame_d = (frame_q == 2'd2) ? 2'd0 : frame_q + 2'd1;
                        end else begin
                            step_d  = step_q + c_AW'(1);
                        end
`ifdef BOSS_CHASE_EN
                        seg_d   = seg_q + c_SW'(1);
`endif
                    end
                    // Turn decision is made on the post-move position.
                    if (w_blocked_now || w_blocked_next) begin
                        fsm_d   = FSM_TURN;
                        dir_d   = w_turn_dir;
                        frame_d = 2'd0;
                        turn_d  = '0;
                    end
                end
            end
            FSM_TURN: begin
                if (w_tick) begin
                    if (turn_q == c_TURN_LAST) begin
                        turn_d = '0;
`ifdef BOSS_CHASE_EN
                        if (w_both_aligned) begin
                            dir_d = chase_dir(x_q, y_q, player_x, player_y);
                        end else begin
                            fsm_d  = FSM_WALK;
                            step_d = '0;
                            seg_d  = '0;
                        end
`else
                        fsm_d  = FSM_WALK;
                        step_d = '0;
`endif
                    end else begin
                        turn_d = turn_q + c_TW'(1);
                    end
                end
            end
            default: begin
                fsm_d = FSM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || !w_active) begin
            fsm_q   <= FSM_IDLE;
            x_q     <= c_X_MIN;
            y_q     <= c_Y_MIN;
            dir_q   <= DIR_RIGHT;
            frame_q <= 2'd0;
            step_q  <= '0;
            turn_q  <= '0;
            pulse_q <= 1'b0;
`ifdef BOSS_CHASE_EN
            seg_q   <= '0;
`endif
        end else if (freeze) begin
            pulse_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
            frame_q <= frame_d;
            step_q  <= step_d;
            turn_q  <= turn_d;
            pulse_q <= pulse_d;
`ifdef BOSS_CHASE_EN
            seg_q   <= seg_d;
`endif
        end
    end

    assign boss_x     = x_q;
    assign boss_y     = y_q;
    assign boss_state = pose_code(dir_q, frame_q);
    assign step_pulse = pulse_q;

endmodule

`default_nettype wire

// File: tb/tb_boss_motion_ctrl.sv
// ============================================================================
//  Module : tb_boss_motion_ctrl
//  Brief  : Self-checking bench for boss_motion_ctrl with a behavioural model.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_boss_motion_ctrl;

    localparam int MOVE_DIV   = 4;
    localparam int ANIM_STEPS = 2;
    localparam int TURN_CYC   = 2;
    localparam int X_MIN = 20, X_MAX = 280, Y_MIN = 20, Y_MAX = 200;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic [3:0] state    = 4'd0;
    logic       freeze   = 1'b0;
    logic [8:0] player_x = 9'd0;
    logic [8:0] player_y = 9'd0;
    wire  [8:0] boss_x;
    wire  [8:0] boss_y;
    wire  [3:0] boss_state;
    wire        step_pulse;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_n = 0;

    // Model: position, direction (UP0 RIGHT1 LEFT2 DOWN3), frame, phase 0 idle/1 walk/2 turn.
    int m_x, m_y, m_dir, m_frame, m_phase, m_div, m_steps, m_turn;
    bit m_pulse;
    int DX[4]       = '{0, 1, -1, 0};
    int DY[4]       = '{-1, 0, 0, 1};
    int NEXT_DIR[4] = '{1, 3, 0, 2};

    boss_motion_ctrl #(
        .MOVE_DIV   (MOVE_DIV),
        .ANIM_STEPS (ANIM_STEPS),
        .TURN_CYC   (TURN_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .state      (state),
        .freeze     (freeze),
        .player_x   (player_x),
        .player_y   (player_y),
        .boss_x     (boss_x),
        .boss_y     (boss_y),
        .boss_state (boss_state),
        .step_pulse (step_pulse)
    );

    always #5 clk = ~clk;

    function automatic bit in_bounds(int x, int y);
        return (x >= X_MIN) && (x <= X_MAX) && (y >= Y_MIN) && (y <= Y_MAX);
    endfunction

    function automatic logic [22:0] exp_vec();
        logic [3:0] pose;
        pose = 4'(m_dir * 3 + m_frame);
        return {m_x[8:0], m_y[8:0], pose, m_pulse};
    endfunction

    function automatic logic [22:0] obs_vec();
        return {boss_x, boss_y, boss_state, step_pulse};
    endfunction

    task automatic model_update();
        bit tk;
        if (rst || state != 4'd6) begin
            m_x = X_MIN; m_y = Y_MIN; m_dir = 1; m_frame = 0; m_pulse = 0;
            m_phase = 0; m_div = 0; m_steps = 0; m_turn = 0;
        end else if (freeze) begin
            m_pulse = 0;
        end else begin
            tk      = (m_div == MOVE_DIV - 1);
            m_div   = (m_div + 1) % MOVE_DIV;
            m_pulse = 0;
            if (m_phase == 0) begin
                m_phase = 1;
            end else if (tk && m_phase == 1) begin
                if (in_bounds(m_x + DX[m_dir], m_y + DY[m_dir])) begin
                    m_x     = m_x + DX[m_dir];
                    m_y     = m_y + DY[m_dir];
                    m_pulse = 1;
                    m_steps = m_steps + 1;
                    if (m_steps == ANIM_STEPS) begin
                        m_steps = 0;
                        m_frame = (m_frame + 1) % 3;
                    end
                end
                if (!in_bounds(m_x + DX[m_dir], m_y + DY[m_dir])) begin
                    m_phase = 2; m_dir = NEXT_DIR[m_dir]; m_frame = 0; m_turn = 0;
                end
            end else if (tk && m_phase == 2) begin
                m_turn = m_turn + 1;
                if (m_turn == TURN_CYC) begin
                    m_phase = 1; m_steps = 0;
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_update();
        cyc_n++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; state = 4'd6; freeze = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            n_cmp++;
            if (obs_vec() !== {9'd20, 9'd20, 4'd3, 1'b0}) begin
                n_bad++;
                $display("FAIL reset_hold got=%h exp=%h", obs_vec(), {9'd20, 9'd20, 4'd3, 1'b0});
            end
        end
    endtask

`ifdef BOSS_CHASE_EN
    task automatic test_chase();
        bit found = 0;
        bit first = 1;
        int bad_order = 0;
        rst = 1'b0; player_x = 9'd100; player_y = 9'd30; state = 4'd6;
        for (int i = 0; i < 3000 && !found; i++) begin
            cyc();
            if (step_pulse && first) begin
                first = 0;
                n_cmp++;
                if (boss_state / 3 !== 4'd1) begin
                    n_bad++;
                    $display("FAIL chase_first_dir got=%0d exp=1", boss_state / 3);
                end
            end
            if (step_pulse && boss_y > 9'd20 && boss_x != 9'd100) bad_order++;
            if (boss_x == 9'd100 && boss_y == 9'd30) found = 1;
        end
        n_cmp++;
        if (!found || bad_order != 0) begin
            n_bad++;
            $display("FAIL chase_reach got=(%0d,%0d) order_err=%0d exp=(100,30)", boss_x, boss_y, bad_order);
        end
        for (int i = 0; i < 100; i++) begin
            cyc();
            n_cmp++;
            if ({boss_x, boss_y, step_pulse} !== {9'd100, 9'd30, 1'b0}) begin
                n_bad++;
                $display("FAIL chase_park got=(%0d,%0d,%0b) exp=(100,30,0)", boss_x, boss_y, step_pulse);
            end
        end
    endtask
`else
    task automatic test_walk();
        int exp_pre[10] = '{0, 0, 1, 1, 2, 2, 0, 0, 1, 1};
        logic [3:0] prev;
        int k = 0;
        rst = 1'b0; state = 4'd2;
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                if (n_bad <= 30) $display("FAIL idle_state got=%h exp=%h", obs_vec(), exp_vec());
            end
        end
        state = 4'd6;
        for (int i = 0; i < 200 && k < 10; i++) begin
            prev = boss_state;
            cyc();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                if (n_bad <= 30) $display("FAIL walk_model got=%h exp=%h", obs_vec(), exp_vec());
            end
            if (step_pulse) begin
                n_cmp++;
                if (boss_x !== 9'(20 + k + 1) || (prev % 3) !== 4'(exp_pre[k])) begin
                    n_bad++;
                    $display("FAIL walk_step%0d got x=%0d preframe=%0d exp x=%0d preframe=%0d",
                             k, boss_x, prev % 3, 20 + k + 1, exp_pre[k]);
                end
                k++;
            end
        end
        n_cmp++;
        if (k != 10 || boss_x !== 9'd30 || boss_y !== 9'd20) begin
            n_bad++;
            $display("FAIL walk_10 got steps=%0d x=%0d y=%0d exp steps=10 x=30 y=20", k, boss_x, boss_y);
        end
    endtask

    task automatic test_turn();
        bit found = 0;
        int t0, gap;
        for (int i = 0; i < 2000 && !found; i++) begin
            cyc();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                if (n_bad <= 30) $display("FAIL right_model got=%h exp=%h", obs_vec(), exp_vec());
            end
            if (step_pulse && boss_x == 9'd280) found = 1;
        end
        n_cmp++;
        if (!found || boss_state !== 4'd9 || boss_y !== 9'd20) begin
            n_bad++;
            $display("FAIL turn_entry got found=%0b pose=%0d y=%0d exp found=1 pose=9 y=20", found, boss_state, boss_y);
        end
        t0 = cyc_n;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            cyc();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                if (n_bad <= 30) $display("FAIL turn_model got=%h exp=%h", obs_vec(), exp_vec());
            end
            if (step_pulse) found = 1;
        end
        gap = cyc_n - t0;
        n_cmp++;
        if (!found || boss_x !== 9'd280 || boss_y !== 9'd21 || gap != (TURN_CYC + 1) * MOVE_DIV) begin
            n_bad++;
            $display("FAIL turn_exit got=(%0d,%0d) gap=%0d exp=(280,21) gap=%0d", boss_x, boss_y, gap, (TURN_CYC + 1) * MOVE_DIV);
        end
    endtask

    task automatic test_patrol_loop();
        bit found = 0;
        int steps = 0;
        for (int i = 0; i < 6000 && !found; i++) begin
            cyc();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                if (n_bad <= 30) $display("FAIL loop_model got=%h exp=%h", obs_vec(), exp_vec());
            end
            if (step_pulse) steps++;
            if (step_pulse && boss_x == 9'd20 && boss_y == 9'd20) found = 1;
        end
        n_cmp++;
        if (!found || boss_state !== 4'd3 || steps != (Y_MAX - 21) + (X_MAX - X_MIN) + (Y_MAX - Y_MIN)) begin
            n_bad++;
            $display("FAIL loop_home got found=%0b pose=%0d steps=%0d exp found=1 pose=3 steps=%0d",
                     found, boss_state, steps, (Y_MAX - 21) + (X_MAX - X_MIN) + (Y_MAX - Y_MIN));
        end
    endtask

    task automatic test_freeze_exit();
        logic [21:0] snap;
        bit found = 0;
        int t0, gap;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc();
            if (step_pulse) found = 1;
        end
        cyc();
        snap   = {boss_x, boss_y, boss_state};
        freeze = 1'b1;
        for (int i = 0; i < 50; i++) begin
            cyc();
            n_cmp++;
            if (obs_vec() !== {snap, 1'b0} || obs_vec() !== exp_vec()) begin
                n_bad++;
                if (n_bad <= 30) $display("FAIL freeze_hold got=%h exp=%h", obs_vec(), {snap, 1'b0});
            end
        end
        freeze = 1'b0;
        t0 = cyc_n;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                if (n_bad <= 30) $display("FAIL release_model got=%h exp=%h", obs_vec(), exp_vec());
            end
            if (step_pulse) found = 1;
        end
        gap = cyc_n - t0;
        n_cmp++;
        if (!found || gap != MOVE_DIV - 1) begin
            n_bad++;
            $display("FAIL release_gap got=%0d exp=%0d", gap, MOVE_DIV - 1);
        end
        for (int i = 0; i < 6; i++) cyc();
        state = 4'd8;
        cyc();
        n_cmp++;
        if (obs_vec() !== {9'd20, 9'd20, 4'd3, 1'b0}) begin
            n_bad++;
            $display("FAIL exit_stage got=%h exp=%h", obs_vec(), {9'd20, 9'd20, 4'd3, 1'b0});
        end
        state = 4'd6;
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            rst   = ($urandom_range(0, 299) == 0);
            state = ($urandom_range(0, 149) == 0) ? 4'($urandom_range(0, 15)) : 4'd6;
            if ($urandom_range(0, 24) == 0) freeze = ~freeze;
            cyc();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                if (n_bad <= 30) $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc_n, obs_vec(), exp_vec());
            end
        end
        rst = 1'b0; freeze = 1'b0; state = 4'd6;
    endtask
`endif

    initial begin
        test_reset();
`ifdef BOSS_CHASE_EN
        test_chase();
`else
        test_walk();
        test_turn();
        test_patrol_loop();
        test_freeze_exit();
        test_random();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
